echo_tap_scheduler: RTL and testbench
=====================================

Name: echo_tap_scheduler

Overview:
- Sequences a shared delay/scale datapath across up to NUM_TAPS echo taps for each incoming audio sample.
- Per sample:
  - pushes the new sample into the datapath history;
  - issues one delay/scale request per enabled tap;
  - accumulates the scaled results and emits one saturated 16-bit output.
- Sits between the sample source and the downstream mixer.
- Owns tap configuration through double-buffered registers, so coefficients never change mid-sample.

Parameters:
NUM_TAPS, 4, number of tap slots; power of two, 2..16
TAP_AW, $clog2(NUM_TAPS), tap address width

Ports:
clk_in  in  1  system clock
reset_in  in  1  synchronous active-high reset
ready_in  in  1  one-cycle strobe: new sample valid on signal_in
signal_in  in  16  signed input sample
done_out  out  1  one-cycle strobe: signal_out updated
signal_out  out  16  signed saturated sum of tap results
overrun_out  out  1  sticky: sample arrived while busy
cfg_we_in  in  1  write shadow tap entry
cfg_addr_in  in  TAP_AW  shadow entry index
cfg_delay_in  in  8  tap delay in samples
cfg_scale_in  in  8  unsigned tap gain, numerator over 2^6
cfg_en_in  in  1  tap enable
cfg_commit_in  in  1  request shadow→active copy at next sample start
dp_push_out  out  1  one-cycle strobe: push dp_sample_out into history
dp_sample_out  out  16  sample to push
dp_req_out  out  1  tap request valid
dp_delay_out  out  8  delay of current tap
dp_scale_out  out  8  scale of current tap
dp_ack_in  in  1  datapath result valid for current request
dp_result_in  in  16  signed scaled tap result

Behaviour:

Reset (reset_in high at a clock edge, including mid-operation):
- State returns to IDLE.
- All shadow and active entries are cleared: delay 0, scale 0, en 0.
- Commit pending cleared.
- Accumulator cleared.
- Outputs:
  - signal_out = 0
  - done_out = 0
  - overrun_out = 0
  - dp_push_out = 0
  - dp_req_out = 0
  - dp_sample_out = 0
  - dp_delay_out = 0
  - dp_scale_out = 0

Config:
- cfg_we_in writes the shadow entry in any state.
- cfg_commit_in sets commit_pending in any state.
- In IDLE, on ready_in, if commit_pending is set: copy all shadow entries to active, clear commit_pending.
  - The copy must include a cfg_we_in write occurring in the same cycle.
- The active table is never modified outside IDLE.

State machine:
- IDLE:
  - On ready_in: latch signal_in into dp_sample_out, clear accumulator, tap index ← 0, go to PUSH.
- PUSH (1 cycle):
  - dp_push_out = 1, then go to ISSUE.
- ISSUE (enabled tap):
  - dp_req_out = 1; dp_delay_out and dp_scale_out = active entry[index].
  - Hold req, delay and scale stable until dp_ack_in is sampled high.
  - In the ack cycle: acc += sign-extended dp_result_in.
- ISSUE (disabled tap):
  - Spend exactly 1 cycle with dp_req_out = 0; no accumulation.
- Advance:
  - After the last index, go to FINISH; otherwise increment the index and stay in ISSUE.
- FINISH (1 cycle):
  - signal_out ← saturate(acc), clamped to [-32768, 32767].
  - done_out ← 1 for exactly one cycle.
  - Return to IDLE.

Arithmetic and handshake rules:
- Accumulator width is 16 + TAP_AW + 1 bits, signed; it cannot overflow internally.
- dp_ack_in is ignored when dp_req_out = 0.
- dp_req_out deasserts in the cycle after the ack unless the next tap is also enabled. For back-to-back enabled taps, req stays high with the new delay/scale.

Latency:
- Measured from the ready_in cycle T, with acks arriving in the same cycle as req: done_out is high in cycle T+NUM_TAPS+3.
- Each cycle of ack wait adds one cycle.
- signal_out holds its value until the next FINISH.

Overrun:
- ready_in in any non-IDLE state sets overrun_out.
- That sample is dropped: no push, no effect on the current computation.
- overrun_out is cleared only by reset.

Test Plan:
1. Reset mid-ISSUE with dp_req_out high → next cycle: state IDLE, dp_req_out=0, signal_out=0, done_out=0, overrun_out=0.
2. NUM_TAPS=4, no commits, ready_in with signal_in=1000 at cycle T → dp_push_out at T+1 with dp_sample_out=1000; dp_req_out never high; done_out at T+7 with signal_out=0.
3. Taps configured (tap0 delay 3 scale 64 en; tap2 delay 10 scale 32 en), then commit, then sample; bench acks immediately with results 500 and −200 → requests observed with (3,64) then (10,32); signal_out=300; done_out at T+7.
4. Two enabled taps, bench returns 30000 for each → signal_out=32767. Repeat with −30000 each → signal_out=−32768.
5. Bench delays the ack on tap0 by 5 cycles → dp_req_out, dp_delay_out and dp_scale_out stable for all 6 cycles; done_out at T+12.
6. Two cases:
   - ready_in pulsed during ISSUE → overrun_out=1, no extra dp_push_out, current result unaffected.
   - Shadow write plus commit during ISSUE → current sample uses the old taps; the next sample uses the new taps.

Source files
------------

// File: rtl/echo_tap_scheduler.sv
// Runs one shared delay/scale datapath over every enabled echo tap per input sample
// and emits the saturated sum. Tap settings are double-buffered and only take effect at a sample start.
module echo_tap_scheduler #(
    parameter int NUM_TAPS = 4,
    parameter int TAP_AW   = $clog2(NUM_TAPS)
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              ready_in,
    input  logic [15:0]       signal_in,
    output logic              done_out,
    output logic [15:0]       signal_out,
    output logic              overrun_out,
    input  logic              cfg_we_in,
    input  logic [TAP_AW-1:0] cfg_addr_in,
    input  logic [7:0]        cfg_delay_in,
    input  logic [7:0]        cfg_scale_in,
    input  logic              cfg_en_in,
    input  logic              cfg_commit_in,
    output logic              dp_push_out,
    output logic [15:0]       dp_sample_out,
    output logic              dp_req_out,
    output logic [7:0]        dp_delay_out,
    output logic [7:0]        dp_scale_out,
    input  logic              dp_ack_in,
    input  logic [15:0]       dp_result_in
);
    localparam int ACC_W = 16 + TAP_AW + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {IDLE, PUSH, ISSUE, FINISH} state_t;

    state_t                  state_reg, state_next;
    logic [TAP_AW-1:0]       idx_reg, idx_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [15:0]             sample_reg, sample_next;
    logic [15:0]             signal_reg;
    logic                    done_reg, overrun_reg, commit_pending_reg;
    logic                    load_active, finish_now, advance;
    logic [15:0]             sat_value;

    logic [7:0] active_delay [NUM_TAPS];
    logic [7:0] active_scale [NUM_TAPS];
    logic       active_en    [NUM_TAPS];

    // Active copy is loaded only at a sample start, and picks up a same-cycle shadow write.
    assign load_active = (state_reg == IDLE) && ready_in && commit_pending_reg;

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
            logic [7:0] shadow_delay_reg, shadow_scale_reg;
            logic [7:0] active_delay_reg, active_scale_reg;
            logic       shadow_en_reg, active_en_reg;
            logic       wr_hit;

            assign wr_hit = cfg_we_in && (cfg_addr_in == TAP_AW'(gi));

            always_ff @(posedge clk_in) begin
                if (reset_in) begin
                    shadow_delay_reg <= '0;
                    shadow_scale_reg <= '0;
                    shadow_en_reg    <= 1'b0;
                    active_delay_reg <= '0;
                    active_scale_reg <= '0;
                    active_en_reg    <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        shadow_delay_reg <= cfg_delay_in;
                        shadow_scale_reg <= cfg_scale_in;
                        shadow_en_reg    <= cfg_en_in;
                    end
                    if (load_active) begin
                        active_delay_reg <= wr_hit ? cfg_delay_in : shadow_delay_reg;
                        active_scale_reg <= wr_hit ? cfg_scale_in : shadow_scale_reg;
                        active_en_reg    <= wr_hit ? cfg_en_in    : shadow_en_reg;
                    end
                end
            end

            assign active_delay[gi] = active_delay_reg;
            assign active_scale[gi] = active_scale_reg;
            assign active_en[gi]    = active_en_reg;
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        acc_next    = acc_reg;
        sample_next = sample_reg;
        finish_now  = 1'b0;
        advance     = 1'b0;
        dp_push_out  = 1'b0;
        dp_req_out   = 1'b0;
        dp_delay_out = '0;
        dp_scale_out = '0;
        case (state_reg)
            IDLE: begin
                if (ready_in) begin
                    sample_next = signal_in;
                    acc_next    = '0;
                    idx_next    = '0;
                    state_next  = PUSH;
                end
            end
            PUSH: begin
                dp_push_out = 1'b1;
                state_next  = ISSUE;
            end
            ISSUE: begin
                if (active_en[idx_reg]) begin
                    dp_req_out   = 1'b1;
                    dp_delay_out = active_delay[idx_reg];
                    dp_scale_out = active_scale[idx_reg];
                    if (dp_ack_in) begin
                        acc_next = acc_reg + $signed({{(ACC_W-16){dp_result_in[15]}}, dp_result_in});
                        advance  = 1'b1;
                    end
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (idx_reg == TAP_AW'(NUM_TAPS - 1))
                        state_next = FINISH;
                    else
                        idx_next = idx_reg + TAP_AW'(1);
                end
            end
            FINISH: begin
                finish_now = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if (acc_reg > SAT_MAX)
            sat_value = 16'h7FFF;
        else if (acc_reg < SAT_MIN)
            sat_value = 16'h8000;
        else
            sat_value = acc_reg[15:0];
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_reg          <= IDLE;
            idx_reg            <= '0;
            acc_reg            <= '0;
            sample_reg         <= '0;
            signal_reg         <= '0;
            done_reg           <= 1'b0;
            overrun_reg        <= 1'b0;
            commit_pending_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            acc_reg    <= acc_next;
            sample_reg <= sample_next;
            done_reg   <= finish_now;
            if (finish_now)
                signal_reg <= sat_value;
            // Samples arriving mid-computation are dropped and flagged until reset.
            if (ready_in && (state_reg != IDLE))
                overrun_reg <= 1'b1;
            if (cfg_commit_in)
                commit_pending_reg <= 1'b1;
            else if (load_active)
                commit_pending_reg <= 1'b0;
        end
    end

    assign done_out      = done_reg;
    assign signal_out    = signal_reg;
    assign overrun_out   = overrun_reg;
    assign dp_sample_out = sample_reg;
endmodule

// File: tb/tb_echo_tap_scheduler.sv
// Randomized bench for echo_tap_scheduler: acts as the datapath and predicts every
// request, the sum, the latency and the overrun flag from a table-level model.
module tb_echo_tap_scheduler;
    localparam int NUM_TAPS = 4;
    localparam int TAP_AW   = $clog2(NUM_TAPS);

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic              reset_in, ready_in, cfg_we_in, cfg_en_in, cfg_commit_in, dp_ack_in;
    logic [15:0]       signal_in, dp_result_in;
    logic [TAP_AW-1:0] cfg_addr_in;
    logic [7:0]        cfg_delay_in, cfg_scale_in;
    logic              done_out, overrun_out, dp_push_out, dp_req_out;
    logic [15:0]       signal_out, dp_sample_out;
    logic [7:0]        dp_delay_out, dp_scale_out;

    echo_tap_scheduler #(.NUM_TAPS(NUM_TAPS)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .ready_in(ready_in), .signal_in(signal_in),
        .done_out(done_out), .signal_out(signal_out), .overrun_out(overrun_out),
        .cfg_we_in(cfg_we_in), .cfg_addr_in(cfg_addr_in), .cfg_delay_in(cfg_delay_in),
        .cfg_scale_in(cfg_scale_in), .cfg_en_in(cfg_en_in), .cfg_commit_in(cfg_commit_in),
        .dp_push_out(dp_push_out), .dp_sample_out(dp_sample_out), .dp_req_out(dp_req_out),
        .dp_delay_out(dp_delay_out), .dp_scale_out(dp_scale_out),
        .dp_ack_in(dp_ack_in), .dp_result_in(dp_result_in)
    );

    int checks = 0;
    int errors = 0;

    // Reference tables
    int m_sh_d [NUM_TAPS], m_sh_s [NUM_TAPS], m_ac_d [NUM_TAPS], m_ac_s [NUM_TAPS];
    bit m_sh_e [NUM_TAPS], m_ac_e [NUM_TAPS];
    bit m_pending, m_overrun;
    int fixed_res [$];
    int fixed_wait [$];
    int last_latency;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_TAPS; i++) begin
            m_sh_d[i] = 0; m_sh_s[i] = 0; m_sh_e[i] = 0;
            m_ac_d[i] = 0; m_ac_s[i] = 0; m_ac_e[i] = 0;
        end
        m_pending = 0;
        m_overrun = 0;
    endtask

    task automatic idle_inputs();
        ready_in = 0; signal_in = 0; cfg_we_in = 0; cfg_addr_in = 0; cfg_delay_in = 0;
        cfg_scale_in = 0; cfg_en_in = 0; cfg_commit_in = 0; dp_ack_in = 0; dp_result_in = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_signal"}, signal_out, 0);
        check({tag, "_overrun"}, overrun_out, 0);
        check({tag, "_push"}, dp_push_out, 0);
        check({tag, "_req"}, dp_req_out, 0);
        check({tag, "_sample"}, dp_sample_out, 0);
        check({tag, "_delay"}, dp_delay_out, 0);
        check({tag, "_scale"}, dp_scale_out, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_in = 1;
        step();
        reset_in = 0;
        model_clear();
        check_reset_outputs("reset");
    endtask

    task automatic cfg_write(input int a, input int d, input int s, input bit e);
        cfg_we_in = 1; cfg_addr_in = TAP_AW'(a); cfg_delay_in = 8'(d); cfg_scale_in = 8'(s); cfg_en_in = e;
        m_sh_d[a] = d; m_sh_s[a] = s; m_sh_e[a] = e;
        step();
        cfg_we_in = 0;
    endtask

    task automatic commit();
        cfg_commit_in = 1;
        m_pending = 1;
        step();
        cfg_commit_in = 0;
    endtask

    // One sample: the bench plays the datapath and compares against the model.
    task automatic run_sample(input logic [15:0] s, input int max_wait, input bit inj_over,
                              input bit inj_cfg, input bit sw, input int sw_a, input int sw_d,
                              input int sw_s, input bit sw_e);
        int c, waits, wait_left, sum, r, a;
        bit in_req;
        logic [7:0] hd, hs;
        logic signed [15:0] rr;
        int q_d [$];
        int q_s [$];
        ready_in = 1;
        signal_in = s;
        if (sw) begin
            cfg_we_in = 1; cfg_addr_in = TAP_AW'(sw_a); cfg_delay_in = 8'(sw_d);
            cfg_scale_in = 8'(sw_s); cfg_en_in = sw_e;
            m_sh_d[sw_a] = sw_d; m_sh_s[sw_a] = sw_s; m_sh_e[sw_a] = sw_e;
        end
        if (m_pending) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                m_ac_d[i] = m_sh_d[i]; m_ac_s[i] = m_sh_s[i]; m_ac_e[i] = m_sh_e[i];
            end
            m_pending = 0;
        end
        for (int i = 0; i < NUM_TAPS; i++)
            if (m_ac_e[i]) begin
                q_d.push_back(m_ac_d[i]);
                q_s.push_back(m_ac_s[i]);
            end
        c = 0; waits = 0; wait_left = 0; sum = 0; in_req = 0; hd = 0; hs = 0;
        dp_ack_in = 0;
        while (c < 300) begin
            step();
            c++;
            ready_in = 0; cfg_we_in = 0; cfg_commit_in = 0;
            if (c == 1) begin
                check("push", dp_push_out, 1);
                check("push_sample", dp_sample_out, s);
            end else if (dp_push_out) begin
                check("extra_push", dp_push_out, 0);
            end
            if (inj_over && c == 3) begin
                ready_in = 1;
                signal_in = 16'($urandom);
                m_overrun = 1;
            end
            if (inj_cfg && c == 3) begin
                a = $urandom_range(0, NUM_TAPS - 1);
                cfg_we_in = 1; cfg_addr_in = TAP_AW'(a); cfg_delay_in = 8'($urandom);
                cfg_scale_in = 8'($urandom); cfg_en_in = 1'($urandom); cfg_commit_in = 1;
                m_sh_d[a] = cfg_delay_in; m_sh_s[a] = cfg_scale_in; m_sh_e[a] = cfg_en_in;
                m_pending = 1;
            end
            // Ack/result are noise unless a request is being answered.
            dp_ack_in = 1'($urandom);
            dp_result_in = 16'($urandom);
            if (in_req && !dp_req_out)
                check("req_dropped", dp_req_out, 1);
            if (dp_req_out) begin
                if (!in_req) begin
                    if (q_d.size() == 0) begin
                        check("unexpected_req", dp_req_out, 0);
                        hd = dp_delay_out; hs = dp_scale_out;
                    end else begin
                        hd = 8'(q_d.pop_front());
                        hs = 8'(q_s.pop_front());
                        check("req_delay", dp_delay_out, hd);
                        check("req_scale", dp_scale_out, hs);
                    end
                    wait_left = (fixed_wait.size() != 0) ? fixed_wait.pop_front()
                                                          : $urandom_range(0, max_wait);
                    waits += wait_left;
                    in_req = 1;
                end else begin
                    check("hold_delay", dp_delay_out, hd);
                    check("hold_scale", dp_scale_out, hs);
                end
                if (wait_left == 0) begin
                    if (fixed_res.size() != 0) begin
                        r = fixed_res.pop_front();
                    end else begin
                        rr = 16'($urandom);
                        r = int'(rr);
                    end
                    dp_ack_in = 1;
                    dp_result_in = 16'(r);
                    sum += r;
                    in_req = 0;
                end else begin
                    dp_ack_in = 0;
                    wait_left--;
                end
            end
            if (done_out) break;
        end
        last_latency = c;
        check("done_seen", done_out, 1);
        check("latency", c, NUM_TAPS + 3 + waits);
        check("req_count_left", q_d.size(), 0);
        check("signal", signal_out, sat16(sum));
        check("overrun", overrun_out, m_overrun);
        $display("sample in=%0d sum=%0d out=%0d latency=%0d overrun=%0d",
                 $signed(s), sum, $signed(signal_out), c, overrun_out);
        dp_ack_in = 0;
        ready_in = 0;
        step();
        check("done_pulse", done_out, 0);
        check("idle_req", dp_req_out, 0);
    endtask

    task automatic run_plain(input logic [15:0] s);
        run_sample(s, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        idle_inputs();
        reset_in = 1;
        step();
        step();
        do_reset();

        // No taps configured: push only, zero output
        run_plain(16'd1000);
        check("t2_signal", signal_out, 0);
        check("t2_latency", last_latency, 7);

        // Two taps with fixed results
        cfg_write(0, 3, 64, 1);
        cfg_write(2, 10, 32, 1);
        commit();
        fixed_res = '{500, -200};
        run_plain(16'd42);
        check("t3_signal", signal_out, 300);
        check("t3_latency", last_latency, 7);

        // Saturation both directions
        fixed_res = '{30000, 30000};
        run_plain(16'd1);
        check("t4_sat_pos", signal_out, 16'h7FFF);
        fixed_res = '{-30000, -30000};
        run_plain(16'd2);
        check("t4_sat_neg", signal_out, 16'h8000);

        // Ack on tap0 held off for 5 cycles
        fixed_wait = '{5, 0};
        run_plain(16'd3);
        check("t5_latency", last_latency, 12);

        // Overrun during ISSUE, then config change during ISSUE
        run_sample(16'd4, 1, 1, 0, 0, 0, 0, 0, 0);
        run_sample(16'd5, 1, 0, 1, 0, 0, 0, 0, 0);
        run_plain(16'd6);

        // Commit pending plus a write in the sample-start cycle
        cfg_write(1, 20, 7, 1);
        commit();
        run_sample(16'd7, 0, 0, 0, 1, 3, 99, 11, 1);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < $urandom_range(0, 2); w++)
                cfg_write($urandom_range(0, NUM_TAPS - 1), $urandom_range(0, 255),
                          $urandom_range(0, 255), 1'($urandom));
            if ($urandom_range(0, 1) == 1) commit();
            run_sample(16'($urandom), 3, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), $urandom_range(0, NUM_TAPS - 1),
                       $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
        end

        // Reset in the middle of an outstanding request
        do_reset();
        cfg_write(1, 7, 9, 1);
        commit();
        ready_in = 1;
        signal_in = 16'd123;
        step();
        ready_in = 0;
        dp_ack_in = 0;
        step();
        ready_in = 1;
        step();
        ready_in = 0;
        check("t1_req_before_reset", dp_req_out, 1);
        check("t1_delay_before_reset", dp_delay_out, 7);
        check("t1_overrun_before_reset", overrun_out, 1);
        reset_in = 1;
        step();
        reset_in = 0;
        model_clear();
        check_reset_outputs("t1_after_reset");
        commit();
        run_plain(16'd9);
        check("t1_tables_cleared", signal_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
